mem_arbiter: RTL and testbench

Round-robin controller that shares the single-port data memory among N_REQ requesters, e.g. the per-core load/store units of the multicore build. It serialises requests into one-at-a-time memory transactions, drives the memory's we/a/wd port from registers, and returns the captured read word with a one-cycle acknowledge to the granted requester. It sits between the core memory stages and the data memory, which writes on negedge clk and reads combinationally.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among N_REQ requesters.
// Each grant runs IDLE -> ACCESS -> RESP, returning the read word with a one-cycle ack.
module mem_arbiter #(
    parameter int WIDTH = 64,
    parameter int N_REQ = 4,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ*WIDTH-1:0] req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic [IDW-1:0]         owner,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_a,
    output logic [WIDTH-1:0]       mem_wd,
    input  logic [WIDTH-1:0]       mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic               mem_we_q, mem_we_d;
    logic [WIDTH-1:0]   mem_a_q, mem_a_d;
    logic [WIDTH-1:0]   mem_wd_q, mem_wd_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic [WIDTH-1:0]   addr_arr [N_REQ];
    logic [WIDTH-1:0]   wdata_arr [N_REQ];
    logic [IDW-1:0]     win;
    logic               found;
    int                 idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*WIDTH +: WIDTH];
        assign wdata_arr[g] = req_wdata[g*WIDTH +: WIDTH];
    end

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        mem_we_d = mem_we_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    mem_a_d  = addr_arr[win];
                    mem_wd_d = wdata_arr[win];
                    mem_we_d = req_we[win];
                    owner_d  = win;
                    ptr_d    = IDW'((int'(win) + 1) % N_REQ);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // The memory commits writes on the preceding negedge, so a write returns its new word.
                rdata_d        = mem_rd;
                mem_we_d       = 1'b0;
                ack_d[owner_q] = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy   = (state_q == ACCESS) || (state_q == RESP);
    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign owner  = owner_q;
    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a negedge-write / combinational-read memory plus a
// round-robin reference model built from the pending-request set and a pointer.
module tb_mem_arbiter;

    localparam int WIDTH = 64;
    localparam int N_REQ = 4;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_we;
    logic [N_REQ*WIDTH-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       rdata;
    logic                   busy;
    logic [1:0]             owner;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_a;
    logic [WIDTH-1:0]       mem_wd;
    logic [WIDTH-1:0]       mem_rd;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] wd_arr [N_REQ];
    logic [WIDTH-1:0] mem [256];
    logic [WIDTH-1:0] ref_mem [256];
    logic [1:0]       mptr;

    int vectors;
    int miscompares;

    mem_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .busy(busy), .owner(owner), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // ---------------- clock / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_addr[g*WIDTH +: WIDTH]  = a_arr[g];
        assign req_wdata[g*WIDTH +: WIDTH] = wd_arr[g];
    end

    assign mem_rd = mem[mem_a[9:2]];
    always @(negedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    // ---------------- reference model ----------------
    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] ptr);
        logic [1:0] i;
        for (int k = 0; k < 4; k++) begin
            i = ptr + 2'(k);
            if (p[i]) return i;
        end
        return ptr;
    endfunction

    function automatic logic [WIDTH-1:0] rand_addr();
        return {54'd0, 10'($urandom_range(0, 1023))};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
        mptr  = 2'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; req_we = '0;
        for (int i = 0; i < N_REQ; i++) begin a_arr[i] = '0; wd_arr[i] = '0; end
        step();
        vectors++;
        if (ack !== 4'b0 || rdata !== '0 || busy !== 1'b0 || owner !== 2'd0 ||
            mem_we !== 1'b0 || mem_a !== '0 || mem_wd !== '0) begin
            miscompares++;
            $display("FAIL reset_values ack=%b rdata=%h busy=%b owner=%0d we=%b a=%h wd=%h (want all 0)",
                     ack, rdata, busy, owner, mem_we, mem_a, mem_wd);
        end
        step();
        rst_n = 1'b1;
        mptr = 2'd0;
    endtask

    task automatic test_single_read();
        mem[5] = 64'hA5; ref_mem[5] = 64'hA5;
        req[2] = 1'b1; req_we[2] = 1'b0; a_arr[2] = 64'h14;
        step();
        vectors++;
        if (mem_a !== 64'h14 || mem_we !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_read_access a=%h we=%b busy=%b want a=14 we=0 busy=1", mem_a, mem_we, busy);
        end
        step();
        vectors++;
        if (ack !== 4'b0100 || rdata !== 64'hA5 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL single_read_ack ack=%b rdata=%h owner=%0d want 0100 a5 2", ack, rdata, owner);
        end
        req[2] = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            miscompares++;
            $display("FAIL single_read_idle busy=%b ack=%b want 0 0000", busy, ack);
        end
        mptr = 2'd3;
    endtask

    task automatic test_write_read();
        int we_cnt;
        we_cnt = 0;
        req[0] = 1'b1; req_we[0] = 1'b1; a_arr[0] = 64'h8; wd_arr[0] = 64'hDEAD;
        step(); if (mem_we) we_cnt++;
        step(); if (mem_we) we_cnt++;
        vectors++;
        if (ack !== 4'b0001 || rdata !== 64'hDEAD) begin
            miscompares++;
            $display("FAIL write_ack ack=%b rdata=%h want 0001 dead", ack, rdata);
        end
        req[0] = 1'b0; req_we[0] = 1'b0;
        ref_mem[2] = 64'hDEAD;
        step(); if (mem_we) we_cnt++;
        vectors++;
        if (we_cnt != 1) begin
            miscompares++;
            $display("FAIL write_we_pulse cycles=%0d want 1", we_cnt);
        end
        req[1] = 1'b1; req_we[1] = 1'b0; a_arr[1] = 64'h8;
        step();
        step();
        vectors++;
        if (ack !== 4'b0010 || rdata !== 64'hDEAD) begin
            miscompares++;
            $display("FAIL read_after_write ack=%b rdata=%h want 0010 dead", ack, rdata);
        end
        req[1] = 1'b0;
        step();
        mptr = 2'd2;
    endtask

    task automatic test_contention();
        int t, last_t, c;
        logic [1:0] w;
        logic [3:0] exp_ack;
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = rand_addr(); req_we[i] = 1'b0;
        end
        req = 4'b1111;
        t = 0; last_t = 0;
        for (int n = 0; n < N_REQ; n++) begin
            w = pick(req, mptr);
            exp_ack = 4'b0001 << w;
            c = 0;
            do begin step(); t++; c++; end while (ack == 4'b0 && c < 12);
            vectors++;
            if (ack !== exp_ack || rdata !== ref_mem[a_arr[w][9:2]]) begin
                miscompares++;
                $display("FAIL contention_order n=%0d ack=%b rdata=%h want %b %h",
                         n, ack, rdata, exp_ack, ref_mem[a_arr[w][9:2]]);
            end
            vectors++;
            if ((n == 0 && t != 2) || (n > 0 && t - last_t != 3)) begin
                miscompares++;
                $display("FAIL contention_spacing n=%0d gap=%0d want %0d", n, t - last_t, (n == 0) ? 2 : 3);
            end
            last_t = t;
            req[w] = 1'b0;
            mptr = w + 2'd1;
        end
        step();
        // {0,3} pending: 0 wins only if the pointer wrapped back to 0.
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            w = pick(req, mptr);
            exp_ack = 4'b0001 << w;
            c = 0;
            do begin step(); c++; end while (ack == 4'b0 && c < 12);
            vectors++;
            if (ack !== exp_ack) begin
                miscompares++;
                $display("FAIL contention_ptr_wrap n=%0d ack=%b want %b", n, ack, exp_ack);
            end
            req[w] = 1'b0;
            mptr = w + 2'd1;
        end
        step();
        req[1] = 1'b1;
        c = 0;
        do begin step(); c++; end while (ack == 4'b0 && c < 12);
        req[1] = 1'b0;
        mptr = 2'd2;
        step();
    endtask

    task automatic test_fairness();
        int c;
        logic [1:0] w, prev_w;
        logic [3:0] exp_ack;
        req_we = '0;
        req = 4'b1010;
        prev_w = 2'd0;
        for (int n = 0; n < 8; n++) begin
            w = pick(req, mptr);
            exp_ack = 4'b0001 << w;
            c = 0;
            do begin step(); c++; end while (ack == 4'b0 && c < 12);
            vectors++;
            if (ack !== exp_ack || (n > 0 && w == prev_w)) begin
                miscompares++;
                $display("FAIL fairness n=%0d ack=%b want %b", n, ack, exp_ack);
            end
            prev_w = w;
            mptr = w + 2'd1;
        end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid_access();
        int bad;
        req[1] = 1'b1; req_we[1] = 1'b0; a_arr[1] = 64'h40;
        step();
        vectors++;
        if (busy !== 1'b1 || rdata === '0) begin
            miscompares++;
            $display("FAIL mid_reset_setup busy=%b rdata=%h want busy 1 and nonzero rdata", busy, rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ack !== 4'b0 || mem_we !== 1'b0 || rdata !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear ack=%b we=%b rdata=%h busy=%b want all 0", ack, mem_we, rdata, busy);
        end
        req = '0;
        step();
        rst_n = 1'b1;
        mptr = 2'd0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack !== 4'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_reset_no_ack bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_idle_stability();
        int bad, diff;
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_we !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_outputs bad_cycles=%0d want 0", bad);
        end
        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        vectors++;
        if (diff != 0) begin
            miscompares++;
            $display("FAIL idle_memory changed_words=%0d want 0", diff);
        end
    endtask

    task automatic test_random();
        logic [1:0] w;
        logic [3:0] exp_ack;
        logic [WIDTH-1:0] exp_data;
        logic exp_we;
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = 1'($urandom_range(0, 1));
            req_we[i] = 1'($urandom_range(0, 1));
            a_arr[i] = rand_addr(); wd_arr[i] = {$urandom, $urandom};
        end
        if (req == 4'b0) req[$urandom_range(0, 3)] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                step();
                vectors++;
                if (busy !== 1'b0 || ack !== 4'b0) begin
                    miscompares++;
                    $display("FAIL random_idle n=%0d busy=%b ack=%b want 0 0000", n, busy, ack);
                end
            end
            w = pick(req, mptr);
            exp_we = req_we[w];
            step();
            vectors++;
            if (mem_a !== a_arr[w] || mem_we !== exp_we || owner !== w || busy !== 1'b1 ||
                (exp_we && mem_wd !== wd_arr[w])) begin
                miscompares++;
                $display("FAIL random_grant n=%0d a=%h we=%b owner=%0d busy=%b want a=%h we=%b owner=%0d busy=1",
                         n, mem_a, mem_we, owner, busy, a_arr[w], exp_we, w);
            end
            if (exp_we) begin
                ref_mem[a_arr[w][9:2]] = wd_arr[w];
            end
            exp_data = ref_mem[a_arr[w][9:2]];
            exp_ack = 4'b0001 << w;
            step();
            vectors++;
            if (ack !== exp_ack || rdata !== exp_data || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL random_ack n=%0d ack=%b rdata=%h we=%b want %b %h 0",
                         n, ack, rdata, mem_we, exp_ack, exp_data);
            end
            mptr = w + 2'd1;
            req[w] = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) != 0) begin
                    req[i] = 1'b1;
                    req_we[i] = 1'($urandom_range(0, 1));
                    a_arr[i] = rand_addr(); wd_arr[i] = {$urandom, $urandom};
                end
            end
            if (req == 4'b0) req[w] = 1'b1;
        end
        req = '0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom} | 64'h1;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_fairness();
        test_reset_mid_access();
        test_idle_stability();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
